vga_ctl: RTL and testbench

VGA_CTL -- requirements
Module: vga_ctl

---
 rtl/vga_ctl.sv | 164 ++++++++++++++++
 tb/tb_vga_ctl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vga_ctl.sv
// vga_ctl -- VGA timing generator and framebuffer scan-out.
//
// Divides the system clock down to a pixel tick, runs horizontal/vertical
// counters, generates the framebuffer read address for a 2x2-scaled
// framebuffer, and registers sync/active/colour on each pixel tick.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active low
//   en           display enable; when low, de/rgb are blanked but timing runs
//   vgactl_addr  framebuffer read address (17-bit, combinational)
//   vgactl_dat   framebuffer data, valid one clk after vgactl_addr
//   vga_hs       horizontal sync, active low (registered)
//   vga_vs       vertical sync, active low (registered)
//   vga_de       active-video flag (registered)
//   vga_rgb      pixel colour, zero outside active video (registered)
//   frame_pulse  one-clk pulse as the vertical counter enters blanking
module vga_ctl #(
  parameter int CLK_DIV     = 2,
  parameter int COLOR_WIDTH = 8,
  parameter int FB_W        = 320,
  parameter int H_ACT       = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACT       = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic [16:0]            vgactl_addr,
  input  logic [COLOR_WIDTH-1:0] vgactl_dat,
  output logic                   vga_hs,
  output logic                   vga_vs,
  output logic                   vga_de,
  output logic [COLOR_WIDTH-1:0] vga_rgb,
  output logic                   frame_pulse
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HCW   = $clog2(H_TOT);
  localparam int VCW   = $clog2(V_TOT);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOT - 1);
  localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOT - 1);

  // State
  logic [DW-1:0]          div_q, div_d;
  logic [HCW-1:0]         hcnt_q, hcnt_d;
  logic [VCW-1:0]         vcnt_q, vcnt_d;
  logic [16:0]            row_base_q, row_base_d;
  logic                   hs_q, hs_d;
  logic                   vs_q, vs_d;
  logic                   de_q, de_d;
  logic [COLOR_WIDTH-1:0] rgb_q, rgb_d;
  logic                   fp_q, fp_d;

  // Decode
  logic        tick;
  logic        h_end;
  logic        v_end;
  logic        active;
  logic        hsync_n;
  logic        vsync_n;
  logic        show;
  logic [31:0] h32;
  logic [31:0] v32;

  always_comb begin
    h32     = 32'(hcnt_q);
    v32     = 32'(vcnt_q);
    tick    = (div_q == DIV_LAST);
    h_end   = (hcnt_q == H_LAST);
    v_end   = (vcnt_q == V_LAST);
    active  = (h32 < 32'(H_ACT)) && (v32 < 32'(V_ACT));
    hsync_n = !((h32 >= 32'(H_ACT + H_FP)) && (h32 < 32'(H_ACT + H_FP + H_SYNC)));
    vsync_n = !((v32 >= 32'(V_ACT + V_FP)) && (v32 < 32'(V_ACT + V_FP + V_SYNC)));
    show    = active && en;
  end

  // Each framebuffer row covers two display lines and each column two
  // pixels, so the address is the row base plus half the pixel column.
  always_comb begin
    if (active) vgactl_addr = row_base_q + 17'(hcnt_q >> 1);
    else        vgactl_addr = row_base_q;
  end

  // Counters and row base
  always_comb begin
    div_d      = tick ? '0 : div_q + 1'b1;
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    row_base_d = row_base_q;
    if (tick) begin
      hcnt_d = h_end ? '0 : hcnt_q + 1'b1;
      if (h_end) begin
        vcnt_d = v_end ? '0 : vcnt_q + 1'b1;
        // Advance the row base after the second line of each framebuffer
        // row. The wrap out of the last active line is skipped so the base
        // held through vertical blanking stays a legal framebuffer address.
        if (v_end)
          row_base_d = '0;
        else if (vcnt_q[0] && (v32 < 32'(V_ACT - 1)))
          row_base_d = row_base_q + 17'(FB_W);
      end
    end
  end

  // Output capture: on a tick, register the state of the pixel the
  // counters point at now (before they advance). The address has been
  // stable since the previous tick, so vgactl_dat is valid here.
  always_comb begin
    hs_d  = hs_q;
    vs_d  = vs_q;
    de_d  = de_q;
    rgb_d = rgb_q;
    if (tick) begin
      hs_d  = hsync_n;
      vs_d  = vsync_n;
      de_d  = show;
      rgb_d = show ? vgactl_dat : '0;
    end
    // Fires on the edge where vcnt steps from the last active line into
    // vertical blanking; cleared on every other edge.
    fp_d = tick && h_end && (v32 == 32'(V_ACT - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q      <= '0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      row_base_q <= '0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      de_q       <= 1'b0;
      rgb_q      <= '0;
      fp_q       <= 1'b0;
    end else begin
      div_q      <= div_d;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      row_base_q <= row_base_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      de_q       <= de_d;
      rgb_q      <= rgb_d;
      fp_q       <= fp_d;
    end
  end

  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_de      = de_q;
  assign vga_rgb     = rgb_q;
  assign frame_pulse = fp_q;

endmodule

// File: tb/tb_vga_ctl.sv
// tb_vga_ctl -- bench for vga_ctl.
// Two instances: one at default 640x480 timing (reset, first tick, hsync
// onset, early address sweep) and one with a tiny geometry so whole frames
// fit in a short run (frame totals, frame_pulse, maximum address).
// The reference model derives every expected output from the number of
// clocks since reset release using plain division/modulo arithmetic.
module tb_vga_ctl;
  localparam int S_DIV = 3, S_FBW = 8;
  localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 2;
  localparam int S_VA = 8,  S_VF = 1, S_VS = 2, S_VB = 1;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [7:0]  dat  [2];
  logic [16:0] addr [2];
  logic        hs [2], vs [2], de [2], fp [2];
  logic [7:0]  rgb [2];

  int checks = 0, failures = 0;

  // geometry per instance
  int g_d[2], g_fbw[2], g_ha[2], g_hf[2], g_hsy[2], g_ht[2];
  int g_va[2], g_vf[2], g_vsy[2], g_vt[2];

  // model state
  int         c[2];
  logic       e_hs[2], e_vs[2], e_de[2], e_fp[2];
  logic [7:0] e_rgb[2];

  logic [31:0] salt;
  bit          noise, stat_on;
  int          rel_clks, first_hs_low;
  int          fp_seen, win_clks, win_hs, win_vs, win_de, win_fp, max_addr1;

  always #5 clk = ~clk;

  vga_ctl u_big (
    .clk(clk), .rst(rst), .en(en),
    .vgactl_addr(addr[0]), .vgactl_dat(dat[0]),
    .vga_hs(hs[0]), .vga_vs(vs[0]), .vga_de(de[0]), .vga_rgb(rgb[0]),
    .frame_pulse(fp[0])
  );

  vga_ctl #(
    .CLK_DIV(S_DIV), .COLOR_WIDTH(8), .FB_W(S_FBW),
    .H_ACT(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACT(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) u_small (
    .clk(clk), .rst(rst), .en(en),
    .vgactl_addr(addr[1]), .vgactl_dat(dat[1]),
    .vga_hs(hs[1]), .vga_vs(vs[1]), .vga_de(de[1]), .vga_rgb(rgb[1]),
    .frame_pulse(fp[1])
  );

  // framebuffer contents as a hash of the address
  function automatic logic [7:0] fb(int a);
    logic [31:0] x;
    x = 32'(a) * 32'd157 + salt;
    return x[7:0] ^ x[15:8];
  endfunction

  // address of display pixel (h,v): each fb row/column spans two lines/pixels
  function automatic int xaddr(int i, int h, int v);
    int row;
    row = ((v < g_va[i]) ? v : g_va[i] - 1) / 2;
    if (h < g_ha[i] && v < g_va[i]) return row * g_fbw[i] + h / 2;
    return row * g_fbw[i];
  endfunction

  function automatic int addr_at(int i, int cc);
    int p;
    p = (cc / g_d[i]) % (g_ht[i] * g_vt[i]);
    return xaddr(i, p % g_ht[i], p / g_ht[i]);
  endfunction

  task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic step();
    int  p, h, v;
    bit  nt;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        c[i] = 0; e_hs[i] = 1'b1; e_vs[i] = 1'b1;
        e_de[i] = 1'b0; e_rgb[i] = 8'h00; e_fp[i] = 1'b0;
      end else begin
        e_fp[i] = 1'b0;
        if (c[i] % g_d[i] == g_d[i] - 1) begin
          p = (c[i] / g_d[i]) % (g_ht[i] * g_vt[i]);
          h = p % g_ht[i];
          v = p / g_ht[i];
          e_hs[i]  = !(h >= g_ha[i] + g_hf[i] && h < g_ha[i] + g_hf[i] + g_hsy[i]);
          e_vs[i]  = !(v >= g_va[i] + g_vf[i] && v < g_va[i] + g_vf[i] + g_vsy[i]);
          e_de[i]  = (h < g_ha[i]) && (v < g_va[i]) && en;
          e_rgb[i] = e_de[i] ? fb(xaddr(i, h, v)) : 8'h00;
          e_fp[i]  = (p == g_va[i] * g_ht[i] - 1);
        end
        c[i]++;
      end
    end
    rel_clks = rst ? rel_clks + 1 : 0;
    #1;
    // registered framebuffer read; with noise on, junk is presented on
    // every edge that is not a capture
    for (int i = 0; i < 2; i++) begin
      nt = rst && (c[i] % g_d[i] == g_d[i] - 1);
      dat[i] = (noise && !nt) ? 8'($urandom) : fb(int'(addr[i]));
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("addr", i, 32'(addr[i]), addr_at(i, c[i]));
      chk("hs",   i, 32'(hs[i]),   32'(e_hs[i]));
      chk("vs",   i, 32'(vs[i]),   32'(e_vs[i]));
      chk("de",   i, 32'(de[i]),   32'(e_de[i]));
      chk("rgb",  i, 32'(rgb[i]),  32'(e_rgb[i]));
      chk("fp",   i, 32'(fp[i]),   32'(e_fp[i]));
    end
    if (rst && rel_clks == g_d[0]) begin
      chk("first_tick_de",  0, 32'(de[0]),  32'd1);
      chk("first_tick_rgb", 0, 32'(rgb[0]), 32'(fb(0)));
    end
    if (rst && first_hs_low == 0 && hs[0] === 1'b0) first_hs_low = rel_clks;
    if (stat_on && rst) begin
      if (fp[1] === 1'b1) fp_seen++;
      if (fp_seen == 1) begin
        win_clks++;
        if (hs[1] === 1'b0) win_hs++;
        if (vs[1] === 1'b0) win_vs++;
        if (de[1] === 1'b1) win_de++;
        if (fp[1] === 1'b1) win_fp++;
      end
      if (int'(addr[1]) > max_addr1) max_addr1 = int'(addr[1]);
    end
  endtask

  initial begin
    g_d[0] = 2;  g_fbw[0] = 320; g_ha[0] = 640; g_hf[0] = 16; g_hsy[0] = 96; g_ht[0] = 800;
    g_va[0] = 480; g_vf[0] = 10; g_vsy[0] = 2; g_vt[0] = 525;
    g_d[1] = S_DIV; g_fbw[1] = S_FBW; g_ha[1] = S_HA; g_hf[1] = S_HF; g_hsy[1] = S_HS;
    g_ht[1] = S_HA + S_HF + S_HS + S_HB;
    g_va[1] = S_VA; g_vf[1] = S_VF; g_vsy[1] = S_VS; g_vt[1] = S_VA + S_VF + S_VS + S_VB;
    salt = $urandom;
    rst = 1'b0; en = 1'b1; noise = 1'b0; stat_on = 1'b0;
    dat[0] = 8'h00; dat[1] = 8'h00;
    rel_clks = 0; first_hs_low = 0;
    fp_seen = 0; win_clks = 0; win_hs = 0; win_vs = 0; win_de = 0; win_fp = 0; max_addr1 = 0;
    for (int i = 0; i < 2; i++) begin
      c[i] = 0; e_hs[i] = 1'b1; e_vs[i] = 1'b1; e_de[i] = 1'b0; e_rgb[i] = 8'h00; e_fp[i] = 1'b0;
    end

    // reset held
    repeat (4) step();

    // release and run; default instance reaches line 2, small one ~4 frames
    rst = 1'b1;
    stat_on = 1'b1;
    for (int k = 0; k < 3300; k++) begin
      if (k == 2000) noise = 1'b1;
      step();
    end
    stat_on = 1'b0;

    chk("hs_first_low_clks", 0, first_hs_low, 657 * g_d[0]);
    chk("frames_seen",  1, 32'(fp_seen >= 2), 32'd1);
    chk("frame_clks",   1, win_clks, g_ht[1] * g_vt[1] * g_d[1]);
    chk("frame_hs_low", 1, win_hs,   g_vt[1] * g_hsy[1] * g_d[1]);
    chk("frame_vs_low", 1, win_vs,   g_vsy[1] * g_ht[1] * g_d[1]);
    chk("frame_de_hi",  1, win_de,   g_ha[1] * g_va[1] * g_d[1]);
    chk("frame_fp_hi",  1, win_fp,   1);
    chk("max_addr",     1, max_addr1, (g_va[1] / 2 - 1) * g_fbw[1] + g_ha[1] / 2 - 1);

    // display disabled mid-line, then reset mid-frame
    en = 1'b0;
    repeat ($urandom_range(300, 600)) step();
    rst = 1'b0;
    step();
    chk("rst_hs",   0, 32'(hs[0]),   32'd1);
    chk("rst_vs",   0, 32'(vs[0]),   32'd1);
    chk("rst_de",   0, 32'(de[0]),   32'd0);
    chk("rst_rgb",  0, 32'(rgb[0]),  32'd0);
    chk("rst_fp",   1, 32'(fp[1]),   32'd0);
    chk("rst_addr", 1, 32'(addr[1]), 32'd0);
    repeat (2) step();

    // restart with display enabled
    rst = 1'b1;
    en  = 1'b1;
    repeat (800) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
